pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/adder_pkg.sv | 17 +
 rtl/pipelined_adder_if.sv | 39 +++
 rtl/adder_stage.sv | 85 ++++++++
 rtl/pipelined_adder.sv | 101 ++++++++++
 tb/tb_pipelined_adder.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared constants and helpers for the pipelined adder.
//   DEF_NUMBITS  : default operand/result width
//   DEF_STAGES   : default number of pipeline stages
//   slice_width(): width of the slice each stage adds (NUMBITS / STAGES)
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int DEF_NUMBITS = 32;
    localparam int DEF_STAGES  = 4;

    function automatic int slice_width(input int numbits, input int stages);
        return numbits / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
// Operand/result handshake bundle for pipelined_adder.
//   in_valid/in_ready   : operand beat handshake
//   A, B, carryin, sub  : operands, carry into bit 0, subtract mode
//   out_valid/out_ready : result beat handshake
//   result, carryout    : sum and raw carry out of the MSB
//   overflow            : signed overflow flag
// Modports: master drives operands and consumes results; slave is the adder.
// -----------------------------------------------------------------------------
interface pipelined_adder_if
    import adder_pkg::*;
#(
    parameter int NUMBITS = DEF_NUMBITS
);

    logic               in_valid;
    logic               in_ready;
    logic [NUMBITS-1:0] A;
    logic [NUMBITS-1:0] B;
    logic               carryin;
    logic               sub;
    logic               out_valid;
    logic               out_ready;
    logic [NUMBITS-1:0] result;
    logic               carryout;
    logic               overflow;

    modport master (
        output in_valid, A, B, carryin, sub, out_ready,
        input  in_ready, out_valid, result, carryout, overflow
    );

    modport slave (
        input  in_valid, A, B, carryin, sub, out_ready,
        output in_ready, out_valid, result, carryout, overflow
    );

endinterface

// File: rtl/adder_stage.sv
// -----------------------------------------------------------------------------
// adder_stage
// One slice of the pipelined adder: adds the low NUMBITS/STAGES bits of the
// remaining operands plus the incoming carry, and registers the slice carry,
// the valid bit, the still-unprocessed operand bits and the result so far.
//   clk, reset        : clock, synchronous active-high reset (valid bit only)
//   adv               : global advance enable; all registers hold when low
//   vld_in/vld_out    : beat valid entering/leaving this stage
//   carry_in/out      : slice carry in, registered slice carry out
//   a_in/b_in, *_out  : remaining operand bits, low slice first
//   sum_in/sum_out    : completed result slices, shifted down one slice per stage
//   sign_a/b_in/out   : effective operand MSBs (only with PIPELINED_ADDER_OVERFLOW_EN)
// -----------------------------------------------------------------------------
module adder_stage
    import adder_pkg::*;
#(
    parameter int NUMBITS = DEF_NUMBITS,
    parameter int STAGES  = DEF_STAGES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adv,
    input  logic               vld_in,
    input  logic               carry_in,
    input  logic [NUMBITS-1:0] a_in,
    input  logic [NUMBITS-1:0] b_in,
    input  logic [NUMBITS-1:0] sum_in,
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    input  logic               sign_a_in,
    input  logic               sign_b_in,
    output logic               sign_a_out,
    output logic               sign_b_out,
`endif
    output logic               vld_out,
    output logic               carry_out,
    output logic [NUMBITS-1:0] a_out,
    output logic [NUMBITS-1:0] b_out,
    output logic [NUMBITS-1:0] sum_out
);

    localparam int W = slice_width(NUMBITS, STAGES);

    logic [W:0]         slice_sum;
    logic [NUMBITS-1:0] sum_next;

    always_comb begin
        slice_sum = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, carry_in};
    end

    // New slice enters at the top; earlier slices slide down so that after the
    // last stage slice 0 sits in the low bits.
    generate
        if (W == NUMBITS) begin : g_full
            logic unused_sum;
            assign unused_sum = ^sum_in;
            assign sum_next   = slice_sum[W-1:0];
        end else begin : g_part
            logic unused_sum;
            assign unused_sum = ^sum_in[W-1:0];
            assign sum_next   = {slice_sum[W-1:0], sum_in[NUMBITS-1:W]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_out <= 1'b0;
        end else if (adv) begin
            vld_out <= vld_in;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            carry_out <= slice_sum[W];
            a_out     <= a_in >> W;
            b_out     <= b_in >> W;
            sum_out   <= sum_next;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
            sign_a_out <= sign_a_in;
            sign_b_out <= sign_b_in;
`endif
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// NUMBITS-wide adder/subtractor split into STAGES carry-registered slices with
// a valid/ready handshake. Latency STAGES cycles, one beat per cycle.
//   clk   : clock
//   reset : synchronous active-high reset; discards all in-flight beats
//   bus   : pipelined_adder_if.slave (operands in, result out)
// Optional build macro PIPELINED_ADDER_OVERFLOW_EN: carries the effective
// operand signs down the pipe and reports signed overflow; otherwise overflow
// is tied to 0.
// NUMBITS must be an exact multiple of STAGES.
// -----------------------------------------------------------------------------
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int NUMBITS = DEF_NUMBITS,
    parameter int STAGES  = DEF_STAGES
) (
    input  logic              clk,
    input  logic              reset,
    pipelined_adder_if.slave  bus
);

    logic               adv;
    logic               out_valid;
    logic               vld_p   [STAGES+1];
    logic               carry_p [STAGES+1];
    logic [NUMBITS-1:0] a_p     [STAGES+1];
    logic [NUMBITS-1:0] b_p     [STAGES+1];
    logic [NUMBITS-1:0] sum_p   [STAGES+1];
    logic               unused_rem;

    // Valid is masked by reset so the pipe looks empty (and in_ready is high)
    // during the reset cycle itself, not only after it.
    assign out_valid = vld_p[STAGES] && !reset;
    assign adv       = !out_valid || bus.out_ready;

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid;

    // Effective operands: subtract is A + ~B + 1, folded into the carry.
    assign vld_p[0]   = bus.in_valid;
    assign carry_p[0] = bus.carryin ^ bus.sub;
    assign a_p[0]     = bus.A;
    assign b_p[0]     = bus.sub ? ~bus.B : bus.B;
    assign sum_p[0]   = '0;

    // Operand remainders are fully consumed by the last stage.
    assign unused_rem = ^{a_p[STAGES], b_p[STAGES]};

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic sign_a_p [STAGES+1];
    logic sign_b_p [STAGES+1];

    assign sign_a_p[0] = bus.A[NUMBITS-1];
    assign sign_b_p[0] = b_p[0][NUMBITS-1];
`endif

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            adder_stage #(
                .NUMBITS (NUMBITS),
                .STAGES  (STAGES)
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .adv        (adv),
                .vld_in     (vld_p[i]),
                .carry_in   (carry_p[i]),
                .a_in       (a_p[i]),
                .b_in       (b_p[i]),
                .sum_in     (sum_p[i]),
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                .sign_a_in  (sign_a_p[i]),
                .sign_b_in  (sign_b_p[i]),
                .sign_a_out (sign_a_p[i+1]),
                .sign_b_out (sign_b_p[i+1]),
`endif
                .vld_out    (vld_p[i+1]),
                .carry_out  (carry_p[i+1]),
                .a_out      (a_p[i+1]),
                .b_out      (b_p[i+1]),
                .sum_out    (sum_p[i+1])
            );
        end
    endgenerate

    // Outputs read as zero whenever no valid beat is presented, which also
    // gives clean zeros straight out of reset.
    assign bus.result   = out_valid ? sum_p[STAGES] : '0;
    assign bus.carryout = out_valid && carry_p[STAGES];

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    assign bus.overflow = out_valid
                          && (sign_a_p[STAGES] == sign_b_p[STAGES])
                          && (sum_p[STAGES][NUMBITS-1] != sign_a_p[STAGES]);
`else
    assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
// Directed self-checking bench: a 32-bit/4-stage instance and an 8-bit/1-stage
// instance sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pipelined_adder_if #(.NUMBITS(32)) bus ();
    pipelined_adder_if #(.NUMBITS(8))  bus8 ();

    pipelined_adder #(.NUMBITS(32), .STAGES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pipelined_adder #(.NUMBITS(8), .STAGES(1)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    localparam bit OV_EN = 1'b1;
`else
    localparam bit OV_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.carryin   = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.A         = '0;
        bus8.B         = '0;
        bus8.carryin   = 1'b0;
        bus8.sub       = 1'b0;
        bus8.out_ready = 1'b1;
    endtask

    // Waits (bounded) for out_valid on the 32-bit instance, counting negedges
    // since the beat was presented; drops in_valid after the first edge.
    task automatic wait_valid32(output int lat);
        int n;
        n   = 0;
        lat = -1;
        while (lat < 0 && n < 10) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            n++;
            if (bus.out_valid === 1'b1) lat = n;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.result !== 32'h0 || bus.carryout !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%b/%b exp=0/0/0", bus.result, bus.carryout, bus.overflow);
        end
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid8 got=%b exp=0", bus8.out_valid);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_carry();
        int lat;
        bus.A = 32'hFFFF_FFFF; bus.B = 32'h1; bus.sub = 1'b0; bus.carryin = 1'b0;
        bus.in_valid = 1'b1;
        wait_valid32(lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL add_carry_latency got=%0d exp=4", lat);
        end
        checks++;
        if (bus.result !== 32'h0 || bus.carryout !== 1'b1 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL add_carry_value got=%h/%b/%b exp=00000000/1/0", bus.result, bus.carryout, bus.overflow);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_carry_single got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_overflow();
        int lat;
        bus.A = 32'h7FFF_FFFF; bus.B = 32'h1; bus.sub = 1'b0; bus.carryin = 1'b0;
        bus.in_valid = 1'b1;
        wait_valid32(lat);
        checks++;
        if (lat !== 4 || bus.result !== 32'h8000_0000 || bus.carryout !== 1'b0 || bus.overflow !== OV_EN) begin
            failures++;
            $display("FAIL overflow got=lat%0d %h/%b/%b exp=lat4 80000000/0/%b",
                     lat, bus.result, bus.carryout, bus.overflow, OV_EN);
        end
        @(negedge clk);
    endtask

    task automatic test_subtract();
        int lat;
        bus.A = 32'd5; bus.B = 32'd7; bus.sub = 1'b1; bus.carryin = 1'b0;
        bus.in_valid = 1'b1;
        wait_valid32(lat);
        checks++;
        if (lat !== 4 || bus.result !== 32'hFFFF_FFFE || bus.carryout !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL sub_5_7 got=lat%0d %h/%b/%b exp=lat4 fffffffe/0/0",
                     lat, bus.result, bus.carryout, bus.overflow);
        end
        @(negedge clk);
        bus.A = 32'd7; bus.B = 32'd5; bus.sub = 1'b1; bus.carryin = 1'b0;
        bus.in_valid = 1'b1;
        wait_valid32(lat);
        checks++;
        if (lat !== 4 || bus.result !== 32'h2 || bus.carryout !== 1'b1 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL sub_7_5 got=lat%0d %h/%b/%b exp=lat4 00000002/1/0",
                     lat, bus.result, bus.carryout, bus.overflow);
        end
        @(negedge clk);
        bus.sub = 1'b0;
    endtask

    task automatic test_carryin();
        int lat;
        bus.A = 32'h0000_FFFF; bus.B = 32'h0001_0000; bus.sub = 1'b0; bus.carryin = 1'b1;
        bus.in_valid = 1'b1;
        wait_valid32(lat);
        checks++;
        if (lat !== 4 || bus.result !== 32'h0002_0000 || bus.carryout !== 1'b0) begin
            failures++;
            $display("FAIL carryin_ripple got=lat%0d %h/%b exp=lat4 00020000/0",
                     lat, bus.result, bus.carryout);
        end
        @(negedge clk);
        bus.carryin = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_v   [8];
        logic [31:0] b_v   [8];
        logic        s_v   [8];
        logic [31:0] exp_v [8];
        logic [31:0] snap;
        int recv;
        int extra;
        for (int i = 0; i < 8; i++) begin
            a_v[i]   = 32'h1111_1111 * (i + 1);
            b_v[i]   = 32'h0F0F_0F0F + i;
            s_v[i]   = (i % 2) == 1;
            exp_v[i] = s_v[i] ? a_v[i] - b_v[i] : a_v[i] + b_v[i];
        end
        recv = 0;
        snap = '0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 8 && cyc < 11);
            if (cyc < 8) begin
                bus.A = a_v[cyc]; bus.B = b_v[cyc]; bus.sub = s_v[cyc];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc == 8) begin
                snap = bus.result;
                checks++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_ready got=in_ready%b out_valid%b exp=0/1", bus.in_ready, bus.out_valid);
                end
            end else if (cyc == 9 || cyc == 10) begin
                checks++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== snap) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got=%b/%b/%h exp=0/1/%h",
                             cyc, bus.in_ready, bus.out_valid, bus.result, snap);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (bus.result !== exp_v[recv]) begin
                    failures++;
                    $display("FAIL stream_beat%0d got=%h exp=%h", recv, bus.result, exp_v[recv]);
                end
                recv++;
            end
        end
        checks++;
        if (recv !== 8) begin
            failures++;
            $display("FAIL stream_count got=%0d exp=8", recv);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL stream_duplicates got=%0d exp=0", extra);
        end
        bus.sub = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int stale;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.A = 32'(i + 1); bus.B = 32'h1; bus.sub = 1'b0;
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_during got=out_valid%b in_ready%b exp=0/1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_after got=%b exp=0", bus.out_valid);
        end
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL midreset_stale got=%0d exp=0", stale);
        end
    endtask

    task automatic test_single_stage();
        int lat;
        int n;
        @(negedge clk);
        bus8.A = 8'd123; bus8.B = 8'd146; bus8.sub = 1'b0; bus8.carryin = 1'b0;
        bus8.in_valid = 1'b1;
        lat = -1;
        n   = 0;
        while (lat < 0 && n < 10) begin
            @(negedge clk);
            bus8.in_valid = 1'b0;
            n++;
            if (bus8.out_valid === 1'b1) lat = n;
        end
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL single_stage_latency got=%0d exp=1", lat);
        end
        checks++;
        if (bus8.result !== 8'd13 || bus8.carryout !== 1'b1 || bus8.overflow !== 1'b0) begin
            failures++;
            $display("FAIL single_stage_value got=%0d/%b/%b exp=13/1/0", bus8.result, bus8.carryout, bus8.overflow);
        end
        @(negedge clk);
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_stage_single got=%b exp=0", bus8.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_overflow();
        test_subtract();
        test_carryin();
        test_back_to_back();
        test_reset_midflight();
        test_single_stage();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
